cop_ram_arbiter: RTL and testbench
==================================

COP_RAM_ARBITER -- requirements
Module: cop_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, word address width of the copper RAM (2048 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, copper RAM word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports host_addr/host_data/host_valid  input  ADDR_WIDTH/DATA_WIDTH/1  CPU write request.
REQ-006 SHALL have port host_ready  output  1  host write accepted this cycle when host_valid is also high.
REQ-007 SHALL have ports dma_addr/dma_data/dma_valid  input  ADDR_WIDTH/DATA_WIDTH/1  bulk-loader write request.
REQ-008 SHALL have port dma_ready  output  1  DMA write accepted this cycle when dma_valid is also high.
REQ-009 SHALL have ports cop_read_addr/cop_read_req  input  ADDR_WIDTH/1  copper fetch request.
REQ-010 SHALL have port cop_read_ack  output  1  copper read accepted this cycle.
REQ-011 SHALL have ports cop_read_data/cop_read_data_valid  output  DATA_WIDTH/1  fetched word and its strobe.
REQ-012 SHALL have ports ram_write_address/ram_write_data/ram_write_en  output  ADDR_WIDTH/DATA_WIDTH/1  registered RAM write port.
REQ-013 SHALL have ports ram_read_address/ram_read_en  output  ADDR_WIDTH/1  registered RAM read port; ram_read_data  input  DATA_WIDTH  RAM registered read output.

Function
REQ-014 SHALL accept at most one write per cycle; host_ready and dma_ready never both high.
REQ-015 SHALL arbitrate writes round-robin: with both valid, grant the requester not granted last; single valid requester granted immediately unless blocked per REQ-019.
REQ-016 SHALL present an accepted write (cycle T) on ram_write_* with ram_write_en=1 in cycle T+1, for exactly one cycle.
REQ-017 SHALL present an accepted read (cop_read_req && cop_read_ack at T) on ram_read_address with ram_read_en=1 at T+1; cop_read_data_valid=1 and cop_read_data=ram_read_data at T+2, one cycle.
REQ-018 SHALL withhold cop_read_ack at T when cop_read_addr equals the address of the write accepted at T (contention), setting a one-bit defer flag; the read thus observes the new data.
REQ-019 SHALL, while the defer flag is set, deassert both host_ready and dma_ready and assert cop_read_ack if cop_read_req is high, then clear the flag (no read starvation beyond one cycle).
REQ-020 SHALL clear the defer flag if cop_read_req drops while deferred, with no ack.
REQ-021 SHALL never issue ram_read_en and ram_write_en in the same cycle with equal addresses.
REQ-022 SHALL allow a non-contending read and write to be accepted in the same cycle (throughput one read + one write per cycle).
REQ-023 SHALL pass ready signals combinationally from valid/state; no dependency of ready on ready.
REQ-024 SHALL ignore *_addr/*_data when the matching valid/req is low.

Reset
REQ-025 SHALL on reset drive ram_write_en=0, ram_read_en=0, cop_read_data_valid=0, cop_read_ack=0, host_ready=0, dma_ready=0; addresses/data zero.
REQ-026 SHALL on reset clear the defer flag and set round-robin pointer so host wins the first tie.
REQ-027 SHALL discard any write or read accepted in the cycle reset is asserted and any in flight (no RAM strobe after reset).

Structure
REQ-028 SHALL place ADDR_WIDTH/DATA_WIDTH defaults and the requester ID encoding (HOST=0, DMA=1) in shared package cop_pkg.
REQ-029 SHALL implement the two-way round-robin grant as sub-module cop_write_rr (valid[1:0] in, grant[1:0] out, pointer update on accept).

Verification
REQ-030 SHALL cover: host and dma valid continuously, addrs 0x010/0x020 -> grants alternate host,dma,host; ram_write_en every cycle T+1.
REQ-031 SHALL cover: host write 0x123<-0xBEEF and copper read 0x123 same cycle -> ack withheld, write at T+1, read issued T+2, cop_read_data=0xBEEF valid T+3.
REQ-032 SHALL cover: contention then both writers valid during defer cycle -> host_ready=dma_ready=0 that cycle, ack=1, writes resume next cycle.
REQ-033 SHALL cover: dma write 0x7FF, copper read 0x000 same cycle -> both accepted, write and read strobes both at T+1.
REQ-034 SHALL cover: reset asserted the cycle after a read ack -> cop_read_data_valid stays 0, no RAM strobes, first post-reset tie grants host.

Source files
------------

// File: rtl/cop_pkg.sv
// Shared definitions for the copper RAM arbiter: default widths, requester IDs
// and the arbiter state encoding.
package cop_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 16;

  // Requester ID encoding; also the bit index into the write valid/grant vectors.
  localparam int REQ_HOST = 0;
  localparam int REQ_DMA  = 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_DEFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cop_write_rr.sv
// Two-way round-robin write grant. Grant is combinational from valid and the
// priority pointer; the pointer moves past whoever was granted.
module cop_write_rr
  import cop_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // 0: host wins a tie, 1: dma wins a tie.
  logic prio_dma;

  always_comb begin
    grant = 2'b00;
    if (enable && !reset) begin
      if (valid[REQ_HOST] && valid[REQ_DMA]) begin
        if (prio_dma) grant[REQ_DMA]  = 1'b1;
        else          grant[REQ_HOST] = 1'b1;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_dma <= 1'b0;
    end else if (grant[REQ_HOST]) begin
      prio_dma <= 1'b1;
    end else if (grant[REQ_DMA]) begin
      prio_dma <= 1'b0;
    end
  end

endmodule

// File: rtl/cop_ram_arbiter.sv
// Copper RAM port arbiter: one write (host or DMA, round-robin) plus one copper
// read per cycle, with a one-cycle read defer when the read hits the write address.
module cop_ram_arbiter
  import cop_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_data,
  input  logic                  dma_valid,
  output logic                  dma_ready,
  input  logic [ADDR_WIDTH-1:0] cop_read_addr,
  input  logic                  cop_read_req,
  output logic                  cop_read_ack,
  output logic [DATA_WIDTH-1:0] cop_read_data,
  output logic                  cop_read_data_valid,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output arb_state_e            dbg_state
);

  // Handshake: a transfer happens in a cycle where valid/req and ready/ack are
  // both high. ready/ack are combinational from valid/req and registered state
  // only, never from another ready; addr/data are ignored while valid/req is low.

  arb_state_e            state, state_next;
  logic [1:0]            grant;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic                  contention;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  cop_write_rr u_write_rr (
    .clk    (clk),
    .reset  (reset),
    .valid  ({dma_valid, host_valid}),
    .enable (state == ARB_IDLE),
    .grant  (grant)
  );

  assign host_ready  = grant[REQ_HOST];
  assign dma_ready   = grant[REQ_DMA];
  assign wr_accept   = |grant;
  assign wr_addr_sel = grant[REQ_DMA] ? dma_addr : host_addr;
  assign wr_data_sel = grant[REQ_DMA] ? dma_data : host_data;
  assign contention  = wr_accept && cop_read_req && (cop_read_addr == wr_addr_sel);

  always_comb begin
    state_next   = state;
    cop_read_ack = 1'b0;
    if (!reset) begin
      case (state)
        ARB_IDLE: begin
          if (contention) state_next = ARB_DEFER;
          else            cop_read_ack = cop_read_req;
        end
        ARB_DEFER: begin
          // Writes are blocked this cycle, so the deferred read always goes.
          cop_read_ack = cop_read_req;
          state_next   = ARB_IDLE;
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ARB_IDLE;
      wr_en_q             <= 1'b0;
      wr_addr_q           <= '0;
      wr_data_q           <= '0;
      rd_en_q             <= 1'b0;
      rd_addr_q           <= '0;
      cop_read_data_valid <= 1'b0;
    end else begin
      state   <= state_next;
      wr_en_q <= wr_accept;
      if (wr_accept) begin
        wr_addr_q <= wr_addr_sel;
        wr_data_q <= wr_data_sel;
      end
      rd_en_q <= cop_read_ack;
      if (cop_read_ack) rd_addr_q <= cop_read_addr;
      cop_read_data_valid <= rd_en_q;
    end
  end

  // Strobes are masked during reset so nothing in flight reaches the RAM.
  assign ram_write_en      = wr_en_q && !reset;
  assign ram_write_address = wr_addr_q;
  assign ram_write_data    = wr_data_q;
  assign ram_read_en       = rd_en_q && !reset;
  assign ram_read_address  = rd_addr_q;
  assign cop_read_data     = cop_read_data_valid ? ram_read_data : '0;
  assign dbg_state         = state;

endmodule

// File: tb/tb_cop_ram_arbiter.sv
// Directed bench for cop_ram_arbiter with a behavioural registered-read RAM.
module tb_cop_ram_arbiter;
  import cop_pkg::*;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] host_addr, dma_addr, cop_read_addr;
  logic [DW-1:0] host_data, dma_data;
  logic          host_valid, dma_valid, cop_read_req;
  logic          host_ready, dma_ready, cop_read_ack;
  logic [DW-1:0] cop_read_data;
  logic          cop_read_data_valid;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [DW-1:0] ram_write_data, ram_read_data;
  logic          ram_write_en, ram_read_en;
  arb_state_e    dbg_state;

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  cop_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .host_addr           (host_addr),
    .host_data           (host_data),
    .host_valid          (host_valid),
    .host_ready          (host_ready),
    .dma_addr            (dma_addr),
    .dma_data            (dma_data),
    .dma_valid           (dma_valid),
    .dma_ready           (dma_ready),
    .cop_read_addr       (cop_read_addr),
    .cop_read_req        (cop_read_req),
    .cop_read_ack        (cop_read_ack),
    .cop_read_data       (cop_read_data),
    .cop_read_data_valid (cop_read_data_valid),
    .ram_write_address   (ram_write_address),
    .ram_write_data      (ram_write_data),
    .ram_write_en        (ram_write_en),
    .ram_read_address    (ram_read_address),
    .ram_read_en         (ram_read_en),
    .ram_read_data       (ram_read_data),
    .dbg_state           (dbg_state)
  );

  // Registered-read RAM model.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_address] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= mem[ram_read_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_read_data = '0;

    // Reset with every requester active: nothing may be accepted.
    reset = 1'b1;
    host_valid = 1'b1; host_addr = 11'h010; host_data = 16'h1111;
    dma_valid  = 1'b1; dma_addr  = 11'h020; dma_data  = 16'h2222;
    cop_read_req = 1'b1; cop_read_addr = 11'h300;
    tick(); tick(); mid();
    check("rst_host_ready", 32'(host_ready), 0);
    check("rst_dma_ready", 32'(dma_ready), 0);
    check("rst_ack", 32'(cop_read_ack), 0);
    check("rst_wen", 32'(ram_write_en), 0);
    check("rst_ren", 32'(ram_read_en), 0);
    check("rst_dvalid", 32'(cop_read_data_valid), 0);
    check("rst_waddr", 32'(ram_write_address), 0);
    check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));

    // Both writers continuously valid: host, dma, host.
    tick(); reset = 1'b0; cop_read_req = 1'b0;
    mid();
    check("rr_c0_host", 32'(host_ready), 1);
    check("rr_c0_dma", 32'(dma_ready), 0);
    check("rr_c0_wen", 32'(ram_write_en), 0);
    tick(); mid();
    check("rr_c1_host", 32'(host_ready), 0);
    check("rr_c1_dma", 32'(dma_ready), 1);
    check("rr_c1_wen", 32'(ram_write_en), 1);
    check("rr_c1_waddr", 32'(ram_write_address), 32'h010);
    check("rr_c1_wdata", 32'(ram_write_data), 32'h1111);
    tick(); mid();
    check("rr_c2_host", 32'(host_ready), 1);
    check("rr_c2_dma", 32'(dma_ready), 0);
    check("rr_c2_wen", 32'(ram_write_en), 1);
    check("rr_c2_waddr", 32'(ram_write_address), 32'h020);
    check("rr_c2_wdata", 32'(ram_write_data), 32'h2222);
    tick(); host_valid = 1'b0; dma_valid = 1'b0;
    mid();
    check("rr_c3_wen", 32'(ram_write_en), 1);
    check("rr_c3_waddr", 32'(ram_write_address), 32'h010);
    tick(); mid();
    check("rr_c4_wen", 32'(ram_write_en), 0);

    // Host write and copper read to 0x123 in the same cycle: read deferred.
    tick();
    host_valid = 1'b1; host_addr = 11'h123; host_data = 16'hBEEF;
    cop_read_req = 1'b1; cop_read_addr = 11'h123;
    mid();
    check("ct_t0_host", 32'(host_ready), 1);
    check("ct_t0_ack", 32'(cop_read_ack), 0);
    tick(); host_valid = 1'b0;
    mid();
    check("ct_t1_wen", 32'(ram_write_en), 1);
    check("ct_t1_waddr", 32'(ram_write_address), 32'h123);
    check("ct_t1_wdata", 32'(ram_write_data), 32'hBEEF);
    check("ct_t1_ack", 32'(cop_read_ack), 1);
    check("ct_t1_ren", 32'(ram_read_en), 0);
    check("ct_t1_state", 32'(dbg_state), 32'(ARB_DEFER));
    tick(); cop_read_req = 1'b0;
    mid();
    check("ct_t2_ren", 32'(ram_read_en), 1);
    check("ct_t2_raddr", 32'(ram_read_address), 32'h123);
    check("ct_t2_wen", 32'(ram_write_en), 0);
    tick(); mid();
    check("ct_t3_dvalid", 32'(cop_read_data_valid), 1);
    check("ct_t3_data", 32'(cop_read_data), 32'hBEEF);
    tick(); mid();
    check("ct_t4_dvalid", 32'(cop_read_data_valid), 0);

    // Contention, then both writers valid during the defer cycle.
    tick();
    dma_valid = 1'b1; dma_addr = 11'h055; dma_data = 16'hA5A5;
    cop_read_req = 1'b1; cop_read_addr = 11'h055;
    mid();
    check("df_t0_dma", 32'(dma_ready), 1);
    check("df_t0_ack", 32'(cop_read_ack), 0);
    tick();
    host_valid = 1'b1; host_addr = 11'h066; host_data = 16'h6666;
    dma_addr = 11'h077; dma_data = 16'h7777;
    mid();
    check("df_t1_host", 32'(host_ready), 0);
    check("df_t1_dma", 32'(dma_ready), 0);
    check("df_t1_ack", 32'(cop_read_ack), 1);
    check("df_t1_waddr", 32'(ram_write_address), 32'h055);
    tick(); cop_read_req = 1'b0;
    mid();
    check("df_t2_host", 32'(host_ready), 1);
    check("df_t2_dma", 32'(dma_ready), 0);
    check("df_t2_ren", 32'(ram_read_en), 1);
    check("df_t2_raddr", 32'(ram_read_address), 32'h055);
    check("df_t2_wen", 32'(ram_write_en), 0);
    tick(); mid();
    check("df_t3_dma", 32'(dma_ready), 1);
    check("df_t3_dvalid", 32'(cop_read_data_valid), 1);
    check("df_t3_data", 32'(cop_read_data), 32'hA5A5);
    check("df_t3_waddr", 32'(ram_write_address), 32'h066);
    tick(); host_valid = 1'b0; dma_valid = 1'b0;
    mid();
    check("df_t4_wen", 32'(ram_write_en), 1);
    check("df_t4_waddr", 32'(ram_write_address), 32'h077);
    check("df_t4_wdata", 32'(ram_write_data), 32'h7777);

    // Deferred read dropped: flag clears without an ack.
    tick();
    host_valid = 1'b1; host_addr = 11'h0AA; host_data = 16'h0001;
    cop_read_req = 1'b1; cop_read_addr = 11'h0AA;
    mid();
    check("dr_t0_host", 32'(host_ready), 1);
    check("dr_t0_ack", 32'(cop_read_ack), 0);
    tick(); cop_read_req = 1'b0; host_addr = 11'h0BB; host_data = 16'h0002;
    mid();
    check("dr_t1_host", 32'(host_ready), 0);
    check("dr_t1_ack", 32'(cop_read_ack), 0);
    tick(); mid();
    check("dr_t2_host", 32'(host_ready), 1);
    check("dr_t2_ren", 32'(ram_read_en), 0);
    check("dr_t2_state", 32'(dbg_state), 32'(ARB_IDLE));
    tick(); host_valid = 1'b0;
    mid();
    check("dr_t3_waddr", 32'(ram_write_address), 32'h0BB);

    // DMA write 0x7FF and copper read 0x000 together: both accepted.
    tick();
    dma_valid = 1'b1; dma_addr = 11'h7FF; dma_data = 16'h1234;
    cop_read_req = 1'b1; cop_read_addr = 11'h000;
    mid();
    check("nc_t0_dma", 32'(dma_ready), 1);
    check("nc_t0_ack", 32'(cop_read_ack), 1);
    tick(); dma_valid = 1'b0; cop_read_req = 1'b0;
    mid();
    check("nc_t1_wen", 32'(ram_write_en), 1);
    check("nc_t1_waddr", 32'(ram_write_address), 32'h7FF);
    check("nc_t1_ren", 32'(ram_read_en), 1);
    check("nc_t1_raddr", 32'(ram_read_address), 32'h000);
    tick(); mid();
    check("nc_t2_dvalid", 32'(cop_read_data_valid), 1);
    check("nc_t2_data", 32'(cop_read_data), 32'h0000);

    // Host-only write leaves dma with tie priority; then read ack and reset.
    tick(); host_valid = 1'b1; host_addr = 11'h100; host_data = 16'h5555;
    mid();
    check("rs_pre_host", 32'(host_ready), 1);
    tick(); host_valid = 1'b0; cop_read_req = 1'b1; cop_read_addr = 11'h010;
    mid();
    check("rs_t0_ack", 32'(cop_read_ack), 1);
    tick();
    cop_read_req = 1'b0; reset = 1'b1;
    host_valid = 1'b1; dma_valid = 1'b1;
    mid();
    check("rs_t1_ren", 32'(ram_read_en), 0);
    check("rs_t1_wen", 32'(ram_write_en), 0);
    check("rs_t1_host", 32'(host_ready), 0);
    check("rs_t1_dma", 32'(dma_ready), 0);
    tick(); reset = 1'b0;
    mid();
    check("rs_t2_dvalid", 32'(cop_read_data_valid), 0);
    check("rs_t2_ren", 32'(ram_read_en), 0);
    check("rs_t2_host", 32'(host_ready), 1);
    check("rs_t2_dma", 32'(dma_ready), 0);
    tick(); host_valid = 1'b0; dma_valid = 1'b0;
    mid();
    check("rs_t3_dvalid", 32'(cop_read_data_valid), 0);
    check("rs_t3_wen", 32'(ram_write_en), 1);
    check("rs_t3_waddr", 32'(ram_write_address), 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
